// File: rtl/store_unit_pkg.sv
// Shared store-path definitions: funct3 store codes, FSM state codes and lane helpers.
// Imported by the store unit, its merge datapath and the bus interface users.
package store_unit_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_READ  = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_ERR   = 3'd4;

    function automatic logic store_f3_legal(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

    // Store data spread across all lanes at its natural size.
    function automatic logic [31:0] store_replicate(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_SB:   return {4{d[7:0]}};
            F3_SH:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Store request and data-memory port bundle between MEM stage, store unit and memory.
// slave = store unit view, master = the surrounding pipeline/memory view.
interface store_unit_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    logic [2:0]    req_funct3;
    logic          done;
    logic          err;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic [31:0]   mem_rdata;
    logic          mem_rvalid;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;

    modport slave (
        input  req_valid, req_addr, req_data, req_funct3, mem_rdata, mem_rvalid,
        output req_ready, done, err, mem_addr, mem_re, mem_we, mem_wdata, mem_be
    );

    modport master (
        output req_valid, req_addr, req_data, req_funct3, mem_rdata, mem_rvalid,
        input  req_ready, done, err, mem_addr, mem_re, mem_we, mem_wdata, mem_be
    );
endinterface

// File: rtl/store_unit_merge.sv
// Combinational lane merge: places store data into the addressed lanes of old_i.
// Also produces the lane mask and the misalignment flag for the access size.
module store_merge
    import store_unit_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] data_i,
    input  logic [31:0] old_i,
    output logic [31:0] merged_o,
    output logic [3:0]  be_o,
    output logic        misaligned_o
);
    logic [31:0] rep;

    assign rep = store_replicate(funct3_i, data_i);

    always_comb begin
        be_o         = '0;
        misaligned_o = 1'b0;
        case (funct3_i)
            F3_SB: be_o = 4'b0001 << addr_i;
            F3_SH: begin
                be_o         = addr_i[1] ? 4'b1100 : 4'b0011;
                misaligned_o = addr_i[0];
            end
            F3_SW: begin
                be_o         = 4'b1111;
                misaligned_o = (addr_i != 2'b00);
            end
            default: ;
        endcase
    end

    always_comb begin
        merged_o = old_i;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be_o[i]) merged_o[8*i +: 8] = rep[8*i +: 8];
        end
    end
endmodule

// File: rtl/store_unit.sv
// MEM-stage store unit: aligns SB/SH/SW data, drives the data-memory write port,
// and optionally performs read-merge-write for memories without byte enables.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int USE_RMW = 1,
    parameter int AW      = 32
) (
    input  logic         clk,
    input  logic         rst,
    store_unit_if.slave  bus
);
    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          done_q, err_q;

    logic [1:0]    m_addr;
    logic [2:0]    m_f3;
    logic [31:0]   m_data;
    logic [31:0]   m_old;
    logic [31:0]   m_merged;
    logic [3:0]    m_be;
    logic          m_mis;

    // One merge instance serves both paths: live request in IDLE, captured request in WAIT.
    // Outside WAIT the "old" word is the replicated data, giving the direct-write pattern.
    assign m_addr = (state_q == ST_IDLE) ? bus.req_addr[1:0] : addr_q[1:0];
    assign m_f3   = (state_q == ST_IDLE) ? bus.req_funct3    : f3_q;
    assign m_data = (state_q == ST_IDLE) ? bus.req_data      : data_q;
    assign m_old  = (state_q == ST_WAIT) ? bus.mem_rdata     : store_replicate(m_f3, m_data);

    store_merge u_merge (
        .addr_i       (m_addr),
        .funct3_i     (m_f3),
        .data_i       (m_data),
        .old_i        (m_old),
        .merged_o     (m_merged),
        .be_o         (m_be),
        .misaligned_o (m_mis)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    data_d = bus.req_data;
                    f3_d   = bus.req_funct3;
                    if (!store_f3_legal(bus.req_funct3) || m_mis) begin
                        state_d = ST_ERR;
                    end else if ((USE_RMW != 0) && (bus.req_funct3 != F3_SW)) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                        wdata_d = m_merged;
                        be_d    = (USE_RMW != 0) ? 4'b1111 : m_be;
                    end
                end
            end
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d = ST_WRITE;
                    wdata_d = m_merged;
                    be_d    = 4'b1111;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            done_q  <= (state_q == ST_WRITE) || (state_q == ST_ERR);
            err_q   <= (state_q == ST_ERR);
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mem_addr  = {addr_q[AW-1:2], 2'b00};
    assign bus.mem_re    = (state_q == ST_READ);
    assign bus.mem_we    = (state_q == ST_WRITE);
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: one RMW instance, one direct-write instance,
// directed scenarios followed by randomized stores against a byte-level reference model.
module tb_store_unit;
    logic clk;
    logic rst;

    logic        vld [2];
    logic [31:0] adr [2];
    logic [31:0] dat [2];
    logic [2:0]  f3  [2];
    logic [31:0] rdat[2];
    logic        rv  [2];

    logic        rdy [2];
    logic        dn  [2];
    logic        er  [2];
    logic        re  [2];
    logic        we  [2];
    logic [31:0] maddr[2];
    logic [31:0] wdat[2];
    logic [3:0]  be  [2];

    int errors = 0;
    int checks = 0;

    store_unit_if #(.AW(32)) if_r ();
    store_unit_if #(.AW(32)) if_d ();

    store_unit #(.USE_RMW(1), .AW(32)) u_rmw (.clk(clk), .rst(rst), .bus(if_r));
    store_unit #(.USE_RMW(0), .AW(32)) u_dir (.clk(clk), .rst(rst), .bus(if_d));

    assign if_r.req_valid  = vld[0];
    assign if_r.req_addr   = adr[0];
    assign if_r.req_data   = dat[0];
    assign if_r.req_funct3 = f3[0];
    assign if_r.mem_rdata  = rdat[0];
    assign if_r.mem_rvalid = rv[0];
    assign if_d.req_valid  = vld[1];
    assign if_d.req_addr   = adr[1];
    assign if_d.req_data   = dat[1];
    assign if_d.req_funct3 = f3[1];
    assign if_d.mem_rdata  = rdat[1];
    assign if_d.mem_rvalid = rv[1];

    assign rdy[0] = if_r.req_ready;  assign rdy[1] = if_d.req_ready;
    assign dn[0]  = if_r.done;       assign dn[1]  = if_d.done;
    assign er[0]  = if_r.err;        assign er[1]  = if_d.err;
    assign re[0]  = if_r.mem_re;     assign re[1]  = if_d.mem_re;
    assign we[0]  = if_r.mem_we;     assign we[1]  = if_d.mem_we;
    assign maddr[0] = if_r.mem_addr; assign maddr[1] = if_d.mem_addr;
    assign wdat[0]  = if_r.mem_wdata; assign wdat[1] = if_d.mem_wdata;
    assign be[0]  = if_r.mem_be;     assign be[1]  = if_d.mem_be;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: the access covers bytes [off, off+size); covered bytes take data byte
    // (k mod size); uncovered bytes keep memory contents (RMW) or repeat the data (direct).
    task automatic model(input bit rmw, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, input logic [31:0] old,
                         output bit e, output bit uses_read,
                         output logic [31:0] w, output logic [3:0] bm);
        int size;
        int off;
        logic [7:0] db;
        logic [7:0] ob;
        size = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : (f == 3'd2) ? 4 : 0;
        off  = int'(a % 4);
        e = (size == 0) || ((off % (size == 0 ? 1 : size)) != 0);
        uses_read = rmw && (size == 1 || size == 2);
        w  = '0;
        bm = '0;
        if (!e) begin
            for (int k = 0; k < 4; k++) begin
                db = 8'((d >> (8 * (k % size))) & 32'hFF);
                ob = 8'((old >> (8 * k)) & 32'hFF);
                if (k >= off && k < off + size) begin
                    w  = w | (32'(db) << (8 * k));
                    bm = bm | (4'b0001 << k);
                end else begin
                    w = w | (32'(uses_read ? ob : db) << (8 * k));
                end
            end
            if (rmw) bm = 4'b1111;
        end
    endtask

    task automatic txn(input int m, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, input int rdelay, input logic [31:0] old,
                       input bit junk, output logic [31:0] got_w);
        bit e;
        bit rd;
        logic [31:0] w;
        logic [3:0] bm;
        logic [31:0] wa;
        model(m == 0, a, d, f, old, e, rd, w, bm);
        wa = a & 32'hFFFF_FFFC;
        got_w = '0;
        chk("idle_ready", rdy[m], 1);
        vld[m] = 1'b1; adr[m] = a; dat[m] = d; f3[m] = f;
        step();
        vld[m] = 1'b0; dat[m] = $urandom; adr[m] = $urandom; f3[m] = 3'($urandom);
        if (e) begin
            chk("err_t1_we", we[m], 0);
            chk("err_t1_re", re[m], 0);
            chk("err_t1_done", dn[m], 0);
            chk("err_t1_ready", rdy[m], 0);
            step();
            chk("err_t2_done", dn[m], 1);
            chk("err_t2_err", er[m], 1);
            chk("err_t2_we", we[m], 0);
            chk("err_t2_re", re[m], 0);
        end else if (!rd) begin
            chk("wr_t1_we", we[m], 1);
            chk("wr_t1_re", re[m], 0);
            chk("wr_t1_addr", maddr[m], wa);
            chk("wr_t1_wdata", wdat[m], w);
            chk("wr_t1_be", 32'(be[m]), 32'(bm));
            chk("wr_t1_ready", rdy[m], 0);
            got_w = wdat[m];
            step();
            chk("wr_t2_done", dn[m], 1);
            chk("wr_t2_err", er[m], 0);
            chk("wr_t2_we", we[m], 0);
        end else begin
            chk("rmw_re", re[m], 1);
            chk("rmw_re_we", we[m], 0);
            chk("rmw_re_addr", maddr[m], wa);
            chk("rmw_re_ready", rdy[m], 0);
            if (junk) begin
                rv[m] = 1'b1; rdat[m] = ~old;
            end
            step();
            rv[m] = 1'b0;
            for (int i = 0; i < rdelay; i++) begin
                chk("wait_re", re[m], 0);
                chk("wait_we", we[m], 0);
                chk("wait_ready", rdy[m], 0);
                chk("wait_addr", maddr[m], wa);
                step();
            end
            chk("wait_last_we", we[m], 0);
            chk("wait_last_ready", rdy[m], 0);
            rv[m] = 1'b1; rdat[m] = old;
            step();
            rv[m] = 1'b0; rdat[m] = $urandom;
            chk("rmw_we", we[m], 1);
            chk("rmw_we_re", re[m], 0);
            chk("rmw_wdata", wdat[m], w);
            chk("rmw_be", 32'(be[m]), 32'(bm));
            chk("rmw_addr", maddr[m], wa);
            got_w = wdat[m];
            step();
            chk("rmw_done", dn[m], 1);
            chk("rmw_err", er[m], 0);
            chk("rmw_single_we", we[m], 0);
            chk("rmw_done_ready", rdy[m], 1);
        end
        step();
        chk("done_drop", dn[m], 0);
        chk("err_drop", er[m], 0);
    endtask

    initial begin
        logic [31:0] gw;
        logic [2:0]  rf;
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            vld[m] = 1'b0; adr[m] = '0; dat[m] = '0; f3[m] = '0; rdat[m] = '0; rv[m] = 1'b0;
        end
        step();
        step();
        for (int m = 0; m < 2; m++) begin
            chk("rst_ready", rdy[m], 1);
            chk("rst_done", dn[m], 0);
            chk("rst_err", er[m], 0);
            chk("rst_we", we[m], 0);
            chk("rst_re", re[m], 0);
            chk("rst_addr", maddr[m], 0);
            chk("rst_wdata", wdat[m], 0);
        end
        rst = 1'b0;
        step();

        txn(0, 32'h100, 32'hDEADBEEF, 3'b010, 0, 32'h0, 1'b0, gw);
        chk("sw_wdata", gw, 32'hDEADBEEF);
        txn(0, 32'h203, 32'h000000A5, 3'b000, 0, 32'h11223344, 1'b0, gw);
        chk("sb_rmw_wdata", gw, 32'hA5223344);
        txn(0, 32'h302, 32'h0000BEEF, 3'b001, 4, 32'h11223344, 1'b0, gw);
        chk("sh_rmw_wdata", gw, 32'hBEEF3344);
        txn(0, 32'h401, 32'h12345678, 3'b001, 0, 32'h0, 1'b0, gw);
        txn(0, 32'h402, 32'h12345678, 3'b010, 0, 32'h0, 1'b0, gw);
        txn(0, 32'h404, 32'h12345678, 3'b011, 0, 32'h0, 1'b0, gw);
        txn(1, 32'h501, 32'h0000007F, 3'b000, 0, 32'h0, 1'b0, gw);
        chk("dir_sb_wdata", gw, 32'h7F7F7F7F);

        // Reset during WAIT must abort the store.
        vld[0] = 1'b1; adr[0] = 32'h600; dat[0] = 32'h55; f3[0] = 3'b000;
        step();
        vld[0] = 1'b0;
        step();
        rst = 1'b1;
        #2;
        chk("abort_ready_async", rdy[0], 1);
        step();
        rst = 1'b0;
        rv[0] = 1'b1; rdat[0] = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            chk("abort_we", we[0], 0);
            chk("abort_done", dn[0], 0);
            chk("abort_re", re[0], 0);
            chk("abort_ready", rdy[0], 1);
            step();
        end
        rv[0] = 1'b0;

        // New request accepted in the cycle done is high.
        vld[1] = 1'b1; adr[1] = 32'h700; dat[1] = 32'h01020304; f3[1] = 3'b010;
        step();
        vld[1] = 1'b0;
        chk("b2b_we1", we[1], 1);
        step();
        chk("b2b_done1", dn[1], 1);
        chk("b2b_ready", rdy[1], 1);
        vld[1] = 1'b1; adr[1] = 32'h702; dat[1] = 32'h00001234; f3[1] = 3'b001;
        step();
        vld[1] = 1'b0;
        chk("b2b_done_drop", dn[1], 0);
        chk("b2b_we2", we[1], 1);
        chk("b2b_wdata2", wdat[1], 32'h12341234);
        chk("b2b_be2", 32'(be[1]), 32'hC);
        chk("b2b_addr2", maddr[1], 32'h700);
        step();
        chk("b2b_done2", dn[1], 1);
        step();

        for (int n = 0; n < 60; n++) begin
            rf = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            txn(n % 2, $urandom, $urandom, rf, int'($urandom_range(0, 3)), $urandom,
                bit'($urandom_range(0, 1)), gw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
